// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/op transfer in, result with flags out.
// The master modport is the operand source / result sink side; slave is the ALU.
interface alu_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero;
    logic         carry;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, zero, carry
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, zero, carry
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic/shift ops plus a W-cycle shift-add
// multiply, with a one-entry registered result held until the sink accepts it.
module alu_seq #(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] LAST_BIT = SW'(W - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t         state_reg, state_next;
    logic [SW-1:0]  cnt_reg, cnt_next;
    logic [2*W-1:0] acc_reg, acc_next;
    logic [2*W-1:0] mcand_reg, mcand_next;
    logic [W-1:0]   mplier_reg, mplier_next;
    logic [W-1:0]   y_reg, y_next;
    logic           zero_reg, zero_next;
    logic           carry_reg, carry_next;
    logic           out_valid_reg, out_valid_next;

    logic           in_ready;
    logic           in_fire;
    logic           out_fire;
    logic [W-1:0]   alu_y;
    logic           alu_c;
    logic [W:0]     wide;
    logic [2*W-1:0] acc_sum;
    logic [SW-1:0]  sh;

    // A new transfer may land when the output slot is empty or draining this edge.
    assign in_ready = !rst && (state_reg == IDLE) && (!out_valid_reg || bus.out_ready);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_reg && bus.out_ready;
    assign sh       = bus.b[SW-1:0];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.y         = y_reg;
    assign bus.zero      = zero_reg;
    assign bus.carry     = carry_reg;

    // Single-cycle datapath; bit W of the widened result carries the flag.
    always_comb begin
        wide  = '0;
        alu_y = '0;
        alu_c = 1'b0;
        case (bus.op)
            3'b000: begin
                wide  = {1'b0, bus.a} + {1'b0, bus.b};
                alu_y = wide[W-1:0];
                alu_c = wide[W];
            end
            3'b001: begin
                wide  = {1'b0, bus.a} - {1'b0, bus.b};
                alu_y = wide[W-1:0];
                alu_c = wide[W];
            end
            3'b010: alu_y = bus.a & bus.b;
            3'b011: alu_y = bus.a | bus.b;
            3'b100: alu_y = bus.a ^ bus.b;
            3'b101: begin
                wide  = {1'b0, bus.a} << sh;
                alu_y = wide[W-1:0];
                alu_c = wide[W];
            end
            3'b110: begin
                // Guard bit below the LSB catches the last bit shifted out.
                wide  = {bus.a, 1'b0} >> sh;
                alu_y = wide[W:1];
                alu_c = wide[0];
            end
            default: begin
                alu_y = '0;
                alu_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        y_next         = y_reg;
        zero_next      = zero_reg;
        carry_next     = carry_reg;
        out_valid_next = out_valid_reg;
        acc_sum        = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

        if (out_fire) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (in_fire) begin
                    if (bus.op == 3'b111) begin
                        state_next  = MUL;
                        cnt_next    = '0;
                        acc_next    = '0;
                        mcand_next  = {{W{1'b0}}, bus.a};
                        mplier_next = bus.b;
                    end else begin
                        y_next         = alu_y;
                        zero_next      = (alu_y == '0);
                        carry_next     = alu_c;
                        out_valid_next = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_next    = acc_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    state_next     = IDLE;
                    cnt_next       = '0;
                    y_next         = acc_sum[W-1:0];
                    zero_next      = (acc_sum[W-1:0] == '0);
                    carry_next     = |acc_sum[2*W-1:W];
                    out_valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            y_reg         <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            mcand_reg     <= mcand_next;
            mplier_reg    <= mplier_next;
            y_reg         <= y_next;
            zero_reg      <= zero_next;
            carry_reg     <= carry_next;
            out_valid_reg <= out_valid_next;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases then random traffic with backpressure and
// resets, checked every cycle against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 8;

    logic clk;
    logic rst;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: pending result, multiply cycles remaining, staged product.
    bit           known    = 0;
    bit           clean    = 0;
    bit           pend     = 0;
    int           mul_left = 0;
    logic [W-1:0] exp_y    = '0;
    logic         exp_z    = 1'b0;
    logic         exp_c    = 1'b0;
    logic [W:0]   staged   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {carry, y}.
    function automatic logic [W:0] ref_alu(input logic [2:0] op, input int unsigned a,
                                           input int unsigned b);
        int unsigned     mask;
        int unsigned     s;
        int unsigned     r;
        int unsigned     c;
        longint unsigned p;
        mask = (1 << W) - 1;
        s    = b % W;
        r    = 0;
        c    = 0;
        case (op)
            3'd0: begin r = a + b; c = (r >> W) & 1; end
            3'd1: begin r = a - b; c = (a < b) ? 1 : 0; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = a << s; c = (s != 0) ? ((a >> (W - s)) & 1) : 0; end
            3'd6: begin r = a >> s; c = (s != 0) ? ((a >> (s - 1)) & 1) : 0; end
            default: begin
                p = longint'(a) * longint'(b);
                r = int'(p & longint'(mask));
                c = ((p >> W) != 0) ? 1 : 0;
            end
        endcase
        r = r & mask;
        return {c[0], r[W-1:0]};
    endfunction

    task automatic load_result(input logic [W:0] res);
        pend  = 1;
        clean = 0;
        exp_y = res[W-1:0];
        exp_c = res[W];
        exp_z = (res[W-1:0] == '0);
    endtask

    // One clock: drive, check against the model, then advance the model past the edge.
    task automatic cycle(input logic r, input logic iv, input logic [2:0] iop,
                         input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ordy);
        bit exp_in_ready;
        bit fire_in;
        bit fire_out;
        rst           = r;
        bus.in_valid  = iv;
        bus.op        = iop;
        bus.a         = ia;
        bus.b         = ib;
        bus.out_ready = ordy;
        #2;
        exp_in_ready = !r && known && mul_left == 0 && (!pend || ordy);
        check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_in_ready});
        if (known) begin
            check("out_valid", {31'b0, bus.out_valid}, {31'b0, pend});
            if (pend || clean) begin
                check("y", {24'b0, bus.y}, {24'b0, exp_y});
                check("zero", {31'b0, bus.zero}, {31'b0, exp_z});
                check("carry", {31'b0, bus.carry}, {31'b0, exp_c});
            end
        end
        fire_in  = iv && exp_in_ready;
        fire_out = known && !r && pend && ordy;
        if (fire_out)
            $display("out: y=%02h zero=%0d carry=%0d", exp_y, exp_z, exp_c);
        @(posedge clk);
        if (r) begin
            known    = 1;
            clean    = 1;
            pend     = 0;
            mul_left = 0;
            exp_y    = '0;
            exp_z    = 1'b0;
            exp_c    = 1'b0;
        end else if (known) begin
            if (fire_out) pend = 0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) load_result(staged);
            end else if (fire_in) begin
                $display("in:  op=%0d a=%02h b=%02h", iop, ia, ib);
                if (iop == 3'b111) begin
                    mul_left = W;
                    staged   = ref_alu(iop, ia, ib);
                end else begin
                    load_result(ref_alu(iop, ia, ib));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, '0, '0, ordy);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);

        // add with carry out, then subtract pair back-to-back
        cycle(1'b0, 1'b1, 3'd0, 8'hF0, 8'h20, 1'b1);
        cycle(1'b0, 1'b1, 3'd1, 8'h05, 8'h05, 1'b1);
        cycle(1'b0, 1'b1, 3'd1, 8'h03, 8'h05, 1'b1);
        // shifts, including zero shift amount
        cycle(1'b0, 1'b1, 3'd5, 8'h81, 8'h01, 1'b1);
        cycle(1'b0, 1'b1, 3'd6, 8'h81, 8'h03, 1'b1);
        cycle(1'b0, 1'b1, 3'd5, 8'hA7, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 3'd6, 8'hA7, 8'h08, 1'b1);
        idle(1, 1'b1);
        // multiplies with overflow and without, operands changing while busy
        cycle(1'b0, 1'b1, 3'd7, 8'h10, 8'h10, 1'b1);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b1);
        cycle(1'b0, 1'b1, 3'd7, 8'h0C, 8'h0A, 1'b1);
        idle(W + 1, 1'b1);
        // backpressure: result held, new op waits, then drain and accept on one edge
        cycle(1'b0, 1'b1, 3'd4, 8'h3C, 8'h0F, 1'b0);
        cycle(1'b0, 1'b1, 3'd2, 8'hF0, 8'h0F, 1'b0);
        cycle(1'b0, 1'b1, 3'd2, 8'hF0, 8'h0F, 1'b0);
        cycle(1'b0, 1'b1, 3'd2, 8'hF0, 8'h0F, 1'b1);
        idle(1, 1'b1);
        // reset in the 4th cycle of a multiply, then a fresh and
        cycle(1'b0, 1'b1, 3'd7, 8'hFF, 8'hFF, 1'b1);
        idle(3, 1'b1);
        cycle(1'b1, 1'b0, 3'd0, '0, '0, 1'b1);
        idle(W + 2, 1'b1);
        cycle(1'b0, 1'b1, 3'd2, 8'h5B, 8'h01, 1'b1);
        cycle(1'b0, 1'b1, 3'd2, 8'h5A, 8'h01, 1'b1);
        idle(1, 1'b1);

        // random traffic with random backpressure and rare resets
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       iv;
            logic       ordy;
            logic [2:0] iop;
            r    = ($urandom_range(0, 199) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            iop  = 3'($urandom_range(0, 7));
            cycle(r, iv, iop, 8'($urandom), 8'($urandom), ordy);
        end
        idle(W + 2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
